// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and BCD digit limits for the stopwatch counter
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_e;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - control inputs and MM:SS display outputs of the stopwatch counter
interface stopwatch_counter_if;

    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic       running;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       wrapped;

    modport master (
        output tick_in, start_stop, clear,
        input  running, digit0, digit1, digit2, digit3, wrapped
    );

    modport slave (
        input  tick_in, start_stop, clear,
        output running, digit0, digit1, digit2, digit3, wrapped
    );

endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD counter digit that rolls over at MAX and reports its carry
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = SEC_ONES_MAX
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    // Any value at or above MAX rolls to zero, so the digit can never leave its legal range.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (inc) begin
            value_d = (value_q >= MAX) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc & (value_q == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - tick edge detect, run/pause FSM, prescaler and MM:SS BCD count
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_COUNT = 2
) (
    input logic                clock_in,
    input logic                reset,
    stopwatch_counter_if.slave sw
);

    localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_COUNT - 1);

    sw_state_e  state_q, state_d;
    logic       tick_q, tick_d;
    logic [7:0] pre_q, pre_d;
    logic       wrapped_q, wrapped_d;
    logic       rise;
    logic       count_en;
    logic       inc0;
    logic       carry0, carry1, carry2, carry3;

    assign tick_d   = sw.tick_in;
    assign rise     = sw.tick_in & ~tick_q;
    // Gating uses the pre-update state, so a rise alongside start_stop counts only if already running.
    assign count_en = (state_q == RUNNING) & rise;
    assign inc0     = count_en & (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        if (sw.clear) begin
            state_d = IDLE;
        end else if (sw.start_stop) begin
            case (state_q)
                IDLE:    state_d = RUNNING;
                RUNNING: state_d = PAUSED;
                PAUSED:  state_d = RUNNING;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pre_d = pre_q;
        if (sw.clear) begin
            pre_d = 8'd0;
        end else if (count_en) begin
            pre_d = (pre_q == PRE_LAST) ? 8'd0 : pre_q + 8'd1;
        end
    end

    always_comb begin
        wrapped_d = wrapped_q;
        if (sw.clear) begin
            wrapped_d = 1'b0;
        end else if (carry3) begin
            wrapped_d = 1'b1;
        end
    end

    // tick_q keeps following tick_in through reset so a level held high across reset is not an edge.
    always_ff @(posedge clock_in) begin
        tick_q <= tick_d;
        if (reset) begin
            state_q   <= IDLE;
            pre_q     <= 8'd0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            wrapped_q <= wrapped_d;
        end
    end

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (sw.clear),
        .inc      (inc0),
        .value    (sw.digit0),
        .carry    (carry0)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (sw.clear),
        .inc      (carry0),
        .value    (sw.digit1),
        .carry    (carry1)
    );

    bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (sw.clear),
        .inc      (carry1),
        .value    (sw.digit2),
        .carry    (carry2)
    );

    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (sw.clear),
        .inc      (carry2),
        .value    (sw.digit3),
        .carry    (carry3)
    );

    assign sw.running = (state_q == RUNNING);
    assign sw.wrapped = wrapped_q;

endmodule
